// File: rtl/key_cfg_rd_arbiter_pkg.sv
// rtl/key_cfg_rd_arbiter_pkg.sv - shared defaults, tag type and round-robin helper for the key config read arbiter
package key_cfg_rd_arbiter_pkg;

    // Defaults shared with the key extractor and its config writer.
    localparam int C_VLANID_WIDTH_DEF = 12;
    localparam int KEY_OFF_DEF        = 68;
    localparam int KEY_LEN_DEF        = 257;
    localparam int ADDR_W_DEF         = 5;
    localparam int NUM_REQ_DEF        = 4;
    localparam int RD_LAT_DEF         = 1;

    // Wide enough for the largest supported requester count (8).
    localparam int TAG_IDX_W = 3;

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
    } rd_tag_t;

    // Search order of requester idx when the last grant went to ptr:
    // 0 for ptr+1, 1 for ptr+2, ..., n-1 for ptr itself.
    function automatic int rr_distance(input int idx, input int ptr, input int n);
        return (idx - ptr - 1 + 2 * n) % n;
    endfunction

endpackage

// File: rtl/key_cfg_rd_arbiter_rr_arbiter_onehot.sv
// rtl/key_cfg_rd_arbiter_rr_arbiter_onehot.sv - combinational round-robin one-hot arbiter
module rr_arbiter_onehot
    import key_cfg_rd_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     eligible,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    // The eligible requester closest after ptr (with wrap) wins.
    always_comb begin
        int best;
        best  = N;
        grant = '0;
        for (int i = 0; i < N; i++) begin
            if (eligible[i] && (rr_distance(i, int'(ptr), N) < best)) begin
                best = rr_distance(i, int'(ptr), N);
            end
        end
        for (int i = 0; i < N; i++) begin
            grant[i] = eligible[i] && (rr_distance(i, int'(ptr), N) == best);
        end
    end

endmodule

// File: rtl/key_cfg_rd_arbiter.sv
// rtl/key_cfg_rd_arbiter.sv - round-robin sharing of the key offset/mask config RAM read port
module key_cfg_rd_arbiter
    import key_cfg_rd_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = NUM_REQ_DEF,
    parameter int C_VLANID_WIDTH = C_VLANID_WIDTH_DEF,
    parameter int KEY_OFF        = KEY_OFF_DEF,
    parameter int KEY_LEN        = KEY_LEN_DEF,
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int RD_LAT         = RD_LAT_DEF
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_REQ*C_VLANID_WIDTH-1:0]   req_vlan,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic                                ram_rd_en,
    output logic [ADDR_W-1:0]                   ram_addr,
    input  logic [KEY_OFF-1:0]                  ram_key_off,
    input  logic [KEY_LEN-1:0]                  ram_key_mask,
    input  logic                                cfg_wr_en,
    input  logic [ADDR_W-1:0]                   cfg_wr_addr,
    input  logic                                cfg_freeze,
    output logic                                arb_idle,
    output logic [NUM_REQ*KEY_OFF-1:0]          rsp_key_off,
    output logic [NUM_REQ*KEY_LEN-1:0]          rsp_key_mask,
    output logic [NUM_REQ-1:0]                  rsp_valid,
    input  logic [NUM_REQ-1:0]                  rsp_ready
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int TAG_D = RD_LAT + 1;

    logic [ADDR_W-1:0]  req_addr [NUM_REQ];
    logic [NUM_REQ-1:0] pending;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] rsp_fire;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   gnt_idx;
    logic [ADDR_W-1:0]  gnt_addr;
    logic               grant_any;
    logic               tag_any;
    rd_tag_t            tag_q [TAG_D];
    rd_tag_t            tag_out;
    logic               unused_vlan_bits;

    // Only vlan[ADDR_W+3:4] addresses the table; the rest is folded away.
    assign unused_vlan_bits = ^req_vlan;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[i] = req_vlan[i*C_VLANID_WIDTH + 4 +: ADDR_W];
            // A collision only removes the colliding requester; rst_n keeps
            // the combinational grant low while reset is held.
            eligible[i] = rst_n && req_valid[i] && !pending[i] && !cfg_freeze &&
                          !(cfg_wr_en && (cfg_wr_addr == req_addr[i]));
        end
    end

    rr_arbiter_onehot #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .eligible (eligible),
        .ptr      (rr_ptr),
        .grant    (grant)
    );

    assign req_ready = grant;
    assign grant_any = |grant;
    assign rsp_fire  = rsp_valid & rsp_ready;
    assign tag_out   = tag_q[RD_LAT];

    always_comb begin
        gnt_idx  = '0;
        gnt_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gnt_idx  = PTR_W'(i);
                gnt_addr = req_addr[i];
            end
        end
    end

    always_comb begin
        tag_any = 1'b0;
        for (int k = 0; k < TAG_D; k++) begin
            tag_any = tag_any | tag_q[k].valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr       <= PTR_W'(NUM_REQ - 1);
            pending      <= '0;
            ram_rd_en    <= 1'b0;
            ram_addr     <= '0;
            arb_idle     <= 1'b1;
            rsp_valid    <= '0;
            rsp_key_off  <= '0;
            rsp_key_mask <= '0;
            for (int k = 0; k < TAG_D; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            if (grant_any) begin
                rr_ptr   <= gnt_idx;
                ram_addr <= gnt_addr;
            end
            ram_rd_en <= grant_any;
            // pending spans in-flight and held; a grant and a release never
            // hit the same requester in one cycle.
            pending   <= (pending | grant) & ~rsp_fire;
            arb_idle  <= !tag_any && !grant_any;

            tag_q[0] <= '{valid: grant_any, idx: TAG_IDX_W'(gnt_idx)};
            for (int k = 1; k < TAG_D; k++) begin
                tag_q[k] <= tag_q[k-1];
            end

            // Tag at the last stage lines up with RAM data valid.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (tag_out.valid && (tag_out.idx == TAG_IDX_W'(i))) begin
                    rsp_valid[i]                          <= 1'b1;
                    rsp_key_off[i*KEY_OFF +: KEY_OFF]     <= ram_key_off;
                    rsp_key_mask[i*KEY_LEN +: KEY_LEN]    <= ram_key_mask;
                end else if (rsp_fire[i]) begin
                    rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

endmodule
